// File: rtl/hellacache_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hellacache_req_arbiter
//  Description : Shares one data-cache request port between NUM_REQ clients
//                (PTW, core LSU, RoCC). Requests are tagged with the client
//                ID and responses are routed back by that ID. The arbiter
//                enforces fence ordering (M_FLUSH_ALL / M_SFENCE) and caps the
//                number of outstanding response-bearing requests.
//                An optional LR/SC ownership lock is compiled in when the
//                macro HELLACACHE_ARB_LRSC_LOCK_EN is defined.
//  Ports       : clock, reset (async, active-high)
//                req_valid/ready/cmd/addr/tag/data   - client request side
//                cache_req_valid/ready/cmd/addr/data/tag - cache stage-0 side
//                cache_resp_valid/tag/data           - cache response side
//                resp_valid/tag/data                 - routed client responses
//  Revision    : 1.0 - initial release
// ============================================================================
module hellacache_req_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 40,
    parameter int DATA_W       = 64,
    parameter int TAG_W        = 6,
    parameter int MAX_OUT      = 4,
    parameter int LOCK_TIMEOUT = 32,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*5-1:0]      req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      cache_req_valid,
    input  logic                      cache_req_ready,
    output logic [4:0]                cache_req_cmd,
    output logic [ADDR_W-1:0]         cache_req_addr,
    output logic [DATA_W-1:0]         cache_req_data,
    output logic [IDW+TAG_W-1:0]      cache_req_tag,
    input  logic                      cache_resp_valid,
    input  logic [IDW+TAG_W-1:0]      cache_resp_tag,
    input  logic [DATA_W-1:0]         cache_resp_data,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [TAG_W-1:0]          resp_tag,
    output logic [DATA_W-1:0]         resp_data
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUT);

    localparam logic [4:0] c_m_pfr       = 5'b00010;
    localparam logic [4:0] c_m_pfw       = 5'b00011;
    localparam logic [4:0] c_m_flush_all = 5'b00101;
    localparam logic [4:0] c_m_sfence    = 5'b10100;
`ifdef HELLACACHE_ARB_LRSC_LOCK_EN
    localparam logic [4:0] c_m_xlr       = 5'b00110;
    localparam logic [4:0] c_m_xsc       = 5'b00111;
    localparam int LW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [LW-1:0] c_lock_last = LW'(LOCK_TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        S_ARB        = 2'd0,
        S_LOCKED     = 2'd1,
        S_DRAIN      = 2'd2,
        S_FENCE_WAIT = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_owner;
    logic [CNT_W-1:0]   r_out_cnt;
`ifdef HELLACACHE_ARB_LRSC_LOCK_EN
    logic [LW-1:0]      r_lock_cnt;
`endif

    logic [4:0]         w_cmd_a  [NUM_REQ];
    logic [ADDR_W-1:0]  w_addr_a [NUM_REQ];
    logic [TAG_W-1:0]   w_tag_a  [NUM_REQ];
    logic [DATA_W-1:0]  w_data_a [NUM_REQ];

    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [4:0]         w_cmd;
    logic               w_is_fence;
    logic               w_resp_bearing;
    logic               w_cnt_zero;
    logic               w_blocked;
    logic               w_hs;
    logic [IDW-1:0]     w_next_ptr;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [IDW-1:0]     w_resp_id;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_cmd_a[g]  = req_cmd[g*5 +: 5];
            assign w_addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
            assign w_tag_a[g]  = req_tag[g*TAG_W +: TAG_W];
            assign w_data_a[g] = req_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search in ARB; only the owner competes in LOCKED/DRAIN,
    // and nobody competes while waiting for a fence response.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_win   = '0;
        j       = 0;
        if (r_state == S_ARB) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = int'(r_rr_ptr) + k;
                if (j >= NUM_REQ) begin
                    j = j - NUM_REQ;
                end
                if (!w_found && req_valid[j]) begin
                    w_found = 1'b1;
                    w_win   = IDW'(j);
                end
            end
        end else if (r_state == S_LOCKED || r_state == S_DRAIN) begin
            w_found = req_valid[r_owner];
            w_win   = r_owner;
        end
    end

    assign w_cmd          = w_cmd_a[w_win];
    assign w_is_fence     = (w_cmd == c_m_flush_all) || (w_cmd == c_m_sfence);
    assign w_resp_bearing = (w_cmd != c_m_pfr) && (w_cmd != c_m_pfw);
    assign w_cnt_zero     = (r_out_cnt == '0);
    // A fence may only leave once every earlier response has returned.
    assign w_blocked      = ((r_out_cnt == c_max_out) && w_resp_bearing) ||
                            (w_is_fence && !w_cnt_zero);

    assign cache_req_valid = w_found && !w_blocked;
    assign cache_req_cmd   = w_cmd;
    assign cache_req_addr  = w_addr_a[w_win];
    assign cache_req_data  = w_data_a[w_win];
    assign cache_req_tag   = {w_win, w_tag_a[w_win]};
    assign w_hs            = cache_req_valid && cache_req_ready;
    assign w_next_ptr      = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + IDW'(1);

    assign w_resp_id = cache_resp_tag[IDW+TAG_W-1:TAG_W];
    assign resp_tag  = cache_resp_tag[TAG_W-1:0];
    assign resp_data = cache_resp_data;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_route
            assign req_ready[g]  = w_found && (w_win == IDW'(g)) &&
                                   cache_req_ready && !w_blocked;
            assign resp_valid[g] = cache_resp_valid && (w_resp_id == IDW'(g));
        end
    endgenerate

    // Issue and retire in one cycle cancel; a stray response at zero is ignored.
    always_comb begin
        w_cnt_next = r_out_cnt;
        if (w_hs && w_resp_bearing) begin
            if (!cache_resp_valid) begin
                w_cnt_next = r_out_cnt + CNT_W'(1);
            end
        end else if (cache_resp_valid && !w_cnt_zero) begin
            w_cnt_next = r_out_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_ARB;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_out_cnt  <= '0;
`ifdef HELLACACHE_ARB_LRSC_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            r_out_cnt <= w_cnt_next;
            if (w_hs) begin
                r_rr_ptr <= w_next_ptr;
            end
            case (r_state)
                S_ARB, S_LOCKED: begin
                    if (w_found && w_is_fence && !w_cnt_zero) begin
                        r_state <= S_DRAIN;
                        r_owner <= w_win;
                    end else if (w_hs && w_is_fence) begin
                        r_state <= S_FENCE_WAIT;
`ifdef HELLACACHE_ARB_LRSC_LOCK_EN
                    end else if (w_hs && (w_cmd == c_m_xlr)) begin
                        r_state    <= S_LOCKED;
                        r_owner    <= w_win;
                        r_lock_cnt <= '0;
                    end else if (r_state == S_LOCKED) begin
                        if ((w_hs && (w_cmd == c_m_xsc)) || (r_lock_cnt == c_lock_last)) begin
                            r_state <= S_ARB;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + LW'(1);
                        end
`endif
                    end
                end
                S_DRAIN: begin
                    if (!req_valid[r_owner]) begin
                        r_state <= S_ARB;
                    end else if (w_hs) begin
                        r_state <= w_is_fence ? S_FENCE_WAIT : S_ARB;
                    end
                end
                S_FENCE_WAIT: begin
                    if (w_cnt_next == '0) begin
                        r_state <= S_ARB;
                    end
                end
                default: r_state <= S_ARB;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hellacache_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hellacache_req_arbiter
//  Description : Directed self-checking bench for hellacache_req_arbiter
//                (NUM_REQ=2, MAX_OUT=4). Lock tests are compiled when
//                HELLACACHE_ARB_LRSC_LOCK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hellacache_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 40;
    localparam int DATA_W  = 64;
    localparam int TAG_W   = 6;
    localparam int IDW     = 1;

    localparam logic [4:0] M_XRD       = 5'b00000;
    localparam logic [4:0] M_XWR       = 5'b00001;
    localparam logic [4:0] M_PFR       = 5'b00010;
    localparam logic [4:0] M_FLUSH_ALL = 5'b00101;
    localparam logic [4:0] M_XLR       = 5'b00110;
`ifdef HELLACACHE_ARB_LRSC_LOCK_EN
    localparam logic [4:0] M_XSC       = 5'b00111;
`endif

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*5-1:0]      req_cmd;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      cache_req_valid;
    logic                      cache_req_ready;
    logic [4:0]                cache_req_cmd;
    logic [ADDR_W-1:0]         cache_req_addr;
    logic [DATA_W-1:0]         cache_req_data;
    logic [IDW+TAG_W-1:0]      cache_req_tag;
    logic                      cache_resp_valid;
    logic [IDW+TAG_W-1:0]      cache_resp_tag;
    logic [DATA_W-1:0]         cache_resp_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [TAG_W-1:0]          resp_tag;
    logic [DATA_W-1:0]         resp_data;

    int checks = 0;
    int errors = 0;

    hellacache_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .MAX_OUT(4), .LOCK_TIMEOUT(32)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_tag(req_tag), .req_data(req_data),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_req_cmd(cache_req_cmd), .cache_req_addr(cache_req_addr),
        .cache_req_data(cache_req_data), .cache_req_tag(cache_req_tag),
        .cache_resp_valid(cache_resp_valid), .cache_resp_tag(cache_resp_tag),
        .cache_resp_data(cache_resp_data),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic setreq(input int i, input logic v, input logic [4:0] cmd, input logic [5:0] tag);
        req_valid[i]        = v;
        req_cmd[i*5 +: 5]   = cmd;
        req_tag[i*6 +: 6]   = tag;
    endtask

    task automatic rsp(input logic v, input logic [6:0] tag);
        cache_resp_valid = v;
        cache_resp_tag   = tag;
        cache_resp_data  = 64'hD00D_0000_0000_0000 | {57'd0, tag};
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        req_valid       = '0;
        req_cmd         = '0;
        req_tag         = '0;
        req_addr        = {40'h00_0000_0200, 40'h00_0000_0100};
        req_data        = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        cache_req_ready = 1'b0;
        rsp(1'b0, 7'h00);
        cyc();
        cyc();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_cache_valid", cache_req_valid, 1'b0);
        chk("rst_resp_valid", resp_valid, 2'b00);
        reset           = 1'b0;
        cache_req_ready = 1'b1;

        // Alternating grants with both clients streaming M_XRD.
        setreq(0, 1'b1, M_XRD, 6'h01);
        setreq(1, 1'b1, M_XRD, 6'h02);
        #1;
        chk("g0_ready", req_ready, 2'b01);
        chk("g0_tag", cache_req_tag, 7'h01);
        chk("g0_addr", cache_req_addr, 40'h100);
        chk("g0_data", cache_req_data, 64'hAAAA_AAAA_AAAA_AAAA);
        cyc();
        chk("g1_ready", req_ready, 2'b10);
        chk("g1_tag", cache_req_tag, 7'h42);
        chk("g1_addr", cache_req_addr, 40'h200);
        cyc();
        chk("g2_ready", req_ready, 2'b01);
        cyc();
        chk("g3_ready", req_ready, 2'b10);
        cyc();
        chk("full_ready", req_ready, 2'b00);
        chk("full_valid", cache_req_valid, 1'b0);

        // Prefetch passes a full counter and does not consume a slot.
        setreq(0, 1'b0, M_XRD, 6'h01);
        setreq(1, 1'b1, M_PFR, 6'h03);
        #1;
        chk("pfr_ready", req_ready, 2'b10);
        chk("pfr_cmd", cache_req_cmd, M_PFR);
        cyc();
        setreq(1, 1'b1, M_XRD, 6'h04);
        #1;
        chk("pfr_cnt_full", req_ready, 2'b00);

        // Response routing, then issue+retire in the same cycle.
        rsp(1'b1, 7'h6A);
        #1;
        chk("rsp_valid", resp_valid, 2'b10);
        chk("rsp_tag", resp_tag, 6'h2A);
        chk("rsp_data", resp_data, 64'hD00D_0000_0000_006A);
        chk("rsp_blocked", req_ready, 2'b00);
        cyc();
        rsp(1'b1, 7'h05);
        #1;
        chk("same_ready", req_ready, 2'b10);
        chk("same_rsp", resp_valid, 2'b01);
        cyc();
        rsp(1'b0, 7'h00);
        #1;
        chk("cnt3_ready", req_ready, 2'b10);
        cyc();
        #1;
        chk("cnt4_blocked", req_ready, 2'b00);

        // Two responses bring the count down to 2.
        setreq(1, 1'b0, M_XRD, 6'h04);
        rsp(1'b1, 7'h40);
        cyc();
        cyc();
        rsp(1'b0, 7'h00);

        // Fence ordering.
        setreq(0, 1'b1, M_FLUSH_ALL, 6'h10);
        setreq(1, 1'b1, M_XWR, 6'h11);
        #1;
        chk("fence_arb_ready", req_ready, 2'b00);
        chk("fence_arb_valid", cache_req_valid, 1'b0);
        cyc();
        rsp(1'b1, 7'h40);
        #1;
        chk("drain1_ready", req_ready, 2'b00);
        cyc();
        #1;
        chk("drain2_ready", req_ready, 2'b00);
        cyc();
        rsp(1'b0, 7'h00);
        #1;
        chk("fence_fwd_ready", req_ready, 2'b01);
        chk("fence_fwd_cmd", cache_req_cmd, M_FLUSH_ALL);
        chk("fence_fwd_tag", cache_req_tag, 7'h10);
        cyc();
        setreq(0, 1'b0, M_XRD, 6'h00);
        #1;
        chk("fwait_ready", req_ready, 2'b00);
        chk("fwait_valid", cache_req_valid, 1'b0);
        cyc();
        chk("fwait2_ready", req_ready, 2'b00);
        rsp(1'b1, 7'h10);
        #1;
        chk("fwait_rsp_ready", req_ready, 2'b00);
        chk("fwait_rsp_route", resp_valid, 2'b01);
        cyc();
        rsp(1'b0, 7'h00);
        #1;
        chk("post_fence_ready", req_ready, 2'b10);
        chk("post_fence_cmd", cache_req_cmd, M_XWR);
        cyc();
        setreq(1, 1'b0, M_XWR, 6'h11);
        rsp(1'b1, 7'h51);
        cyc();
        rsp(1'b0, 7'h00);

`ifdef HELLACACHE_ARB_LRSC_LOCK_EN
        // LR/SC ownership: client 1 starves until client 0's SC.
        setreq(0, 1'b1, M_XLR, 6'h20);
        setreq(1, 1'b1, M_XRD, 6'h21);
        #1;
        chk("lr_ready", req_ready, 2'b01);
        cyc();
        setreq(0, 1'b1, M_XWR, 6'h22);
        #1;
        chk("lock_wr_ready", req_ready, 2'b01);
        cyc();
        setreq(0, 1'b1, M_XSC, 6'h23);
        #1;
        chk("lock_sc_ready", req_ready, 2'b01);
        cyc();
        setreq(0, 1'b0, M_XRD, 6'h00);
        #1;
        chk("unlock_ready", req_ready, 2'b10);
        cyc();
        setreq(1, 1'b0, M_XRD, 6'h21);
        rsp(1'b1, 7'h20);
        repeat (4) cyc();
        rsp(1'b0, 7'h00);

        // Lock timeout: exactly 32 locked cycles.
        setreq(0, 1'b1, M_XLR, 6'h24);
        #1;
        chk("lr2_ready", req_ready, 2'b01);
        cyc();
        setreq(0, 1'b0, M_XRD, 6'h00);
        setreq(1, 1'b1, M_XRD, 6'h25);
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("lock_starve", req_ready, 2'b00);
            cyc();
        end
        chk("timeout_ready", req_ready, 2'b10);
        cyc();
        setreq(1, 1'b0, M_XRD, 6'h25);
        rsp(1'b1, 7'h24);
        repeat (2) cyc();
        rsp(1'b0, 7'h00);
`endif

        // Three outstanding requests, then an asynchronous reset.
        setreq(1, 1'b1, M_XRD, 6'h30);
        #1;
        chk("pre_rst_a", req_ready, 2'b10);
        cyc();
        cyc();
        setreq(1, 1'b0, M_XRD, 6'h30);
        setreq(0, 1'b1, M_XLR, 6'h31);
        #1;
        chk("pre_rst_c", req_ready, 2'b01);
        cyc();
        setreq(0, 1'b0, M_XRD, 6'h00);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 2'b00);
        chk("mid_rst_valid", cache_req_valid, 1'b0);
        chk("mid_rst_resp", resp_valid, 2'b00);
        cyc();
        reset = 1'b0;
        rsp(1'b1, 7'h41);
        #1;
        chk("post_rst_route", resp_valid, 2'b10);
        cyc();
        rsp(1'b0, 7'h00);
        setreq(0, 1'b1, M_XRD, 6'h01);
        setreq(1, 1'b1, M_XRD, 6'h02);
        #1;
        chk("post_rst_g0", req_ready, 2'b01);
        cyc();
        chk("post_rst_g1", req_ready, 2'b10);
        cyc();
        chk("post_rst_g2", req_ready, 2'b01);
        cyc();
        chk("post_rst_g3", req_ready, 2'b10);
        cyc();
        chk("post_rst_full", req_ready, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
